uart_frame_loader: RTL and testbench

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// -----------------------------------------------------------------------------
// uart_frame_loader
//
// Unpacks a stream of received UART bytes into a bit-addressed image memory.
// Each accepted byte is written LSB first, one bit per cycle, to consecutive
// bit addresses. When the write at address IMG_BITS-1 completes, the frame is
// held (frame_rdy) until the consumer acknowledges it. A partial frame whose
// next byte does not arrive within TIMEOUT idle cycles is abandoned.
//
// Parameters
//   IMG_BITS  frame length in bits (1 .. 2**ADDR_W)
//   ADDR_W    bit-address width of the destination memory
//   TIMEOUT   idle cycles allowed between bytes of one frame
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_rdy       one-cycle pulse: rx_data holds a received byte
//   rx_data      received byte
//   frame_ack    consumer releases the completed frame
//   wr_en        bit-write strobe
//   wr_addr      bit address of the write
//   wr_data      bit value of the write
//   frame_rdy    level: a complete frame is in memory
//   overrun      one-cycle pulse: an incoming byte was dropped
//   timeout_err  one-cycle pulse: a partial frame was abandoned
// -----------------------------------------------------------------------------
module uart_frame_loader #(
    parameter int IMG_BITS = 784,
    parameter int ADDR_W   = 10,
    parameter int TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              frame_rdy,
    output logic              overrun,
    output logic              timeout_err
);

    // The counter only has to reach TIMEOUT-1; the expiry cycle itself is
    // detected by comparison rather than by counting to TIMEOUT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UNPACK    = 2'd1,
        WAIT_BYTE = 2'd2,
        FULL      = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [2:0]        bit_q,     bit_d;
    logic [7:0]        byte_q,    byte_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                // No timer here: the first byte of a frame may come any time.
                if (rx_rdy) begin
                    byte_d  = rx_data;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = UNPACK;
                end
            end

            UNPACK: begin
                if (addr_q == LAST_ADDR) begin
                    // Final bit of the frame: any surplus bits of this byte
                    // are discarded and the address is held at its maximum.
                    state_d = FULL;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        cnt_d   = '0;
                        state_d = WAIT_BYTE;
                    end
                end
            end

            WAIT_BYTE: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_rdy) begin
                    byte_d  = rx_data;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = UNPACK;
                end else if (cnt_q == CNT_LAST) begin
                    addr_d    = '0;
                    bit_d     = 3'd0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FULL: begin
                if (frame_ack) begin
                    addr_d  = '0;
                    bit_d   = 3'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                addr_d  = '0;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        wr_en       = (state_q == UNPACK);
        wr_addr     = addr_q;
        wr_data     = wr_en & byte_q[bit_q];
        frame_rdy   = (state_q == FULL);
        overrun     = overrun_q;
        timeout_err = timeout_q;
        // A byte is dropped whenever the loader cannot accept it.
        overrun_d   = rx_rdy & ((state_q == UNPACK) | (state_q == FULL));
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// -----------------------------------------------------------------------------
// Testbench for uart_frame_loader. Three instances with different parameter
// sets share one stimulus bus; `sel` routes rx_rdy/frame_ack to one instance
// and selects which instance's outputs the write logger observes.
//   u0: defaults (784 bits, 10-bit address, 65535 timeout)
//   u1: 20-bit frame, 5-bit address, timeout 100
//   u2: 784-bit frame, 10-bit address, timeout 100
// -----------------------------------------------------------------------------
module tb_uart_frame_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic       frame_ack = 1'b0;
    logic [7:0] rx_data = 8'h00;
    int         sel = 0;

    always #5 clk = ~clk;

    logic [2:0] rr, fa, we, wd, fr, ov, te;
    logic [9:0] wa0, wa2;
    logic [4:0] wa1;

    assign rr[0] = rx_rdy    && (sel == 0);
    assign rr[1] = rx_rdy    && (sel == 1);
    assign rr[2] = rx_rdy    && (sel == 2);
    assign fa[0] = frame_ack && (sel == 0);
    assign fa[1] = frame_ack && (sel == 1);
    assign fa[2] = frame_ack && (sel == 2);

    uart_frame_loader u0 (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rr[0]), .rx_data(rx_data),
        .frame_ack(fa[0]), .wr_en(we[0]), .wr_addr(wa0), .wr_data(wd[0]),
        .frame_rdy(fr[0]), .overrun(ov[0]), .timeout_err(te[0])
    );

    uart_frame_loader #(.IMG_BITS(20), .ADDR_W(5), .TIMEOUT(100)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rr[1]), .rx_data(rx_data),
        .frame_ack(fa[1]), .wr_en(we[1]), .wr_addr(wa1), .wr_data(wd[1]),
        .frame_rdy(fr[1]), .overrun(ov[1]), .timeout_err(te[1])
    );

    uart_frame_loader #(.IMG_BITS(784), .ADDR_W(10), .TIMEOUT(100)) u2 (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rr[2]), .rx_data(rx_data),
        .frame_ack(fa[2]), .wr_en(we[2]), .wr_addr(wa2), .wr_data(wd[2]),
        .frame_rdy(fr[2]), .overrun(ov[2]), .timeout_err(te[2])
    );

    logic       s_we, s_wd, s_fr, s_ov, s_te;
    logic [9:0] s_wa;

    always_comb begin
        case (sel)
            1:       begin s_we = we[1]; s_wd = wd[1]; s_fr = fr[1]; s_ov = ov[1]; s_te = te[1]; s_wa = {5'b0, wa1}; end
            2:       begin s_we = we[2]; s_wd = wd[2]; s_fr = fr[2]; s_ov = ov[2]; s_te = te[2]; s_wa = wa2; end
            default: begin s_we = we[0]; s_wd = wd[0]; s_fr = fr[0]; s_ov = ov[0]; s_te = te[0]; s_wa = wa0; end
        endcase
    end

    // Cycle counter and write logger (owned solely by these blocks).
    int         cyc = 0;
    int         lcnt = 0, last_cyc = 0, rdy_cyc = 0, ovr_cnt = 0, to_cnt = 0;
    logic       fr_prev = 1'b0;
    logic [9:0] laddr [4096];
    logic       ldata [4096];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_we) begin
            if (lcnt < 4096) begin
                laddr[lcnt] = s_wa;
                ldata[lcnt] = s_wd;
            end
            lcnt++;
            last_cyc = cyc;
        end
        if (s_fr && !fr_prev) rdy_cyc = cyc;
        fr_prev = s_fr;
        if (s_ov) ovr_cnt++;
        if (s_te) to_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    // Number of logged writes (from index b) whose address is not a0+i.
    function automatic int seq_bad(input int b, input int n, input int a0);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (laddr[b+i] !== 10'(a0 + i)) bad++;
        return bad;
    endfunction

    // Logged write data packed LSB first.
    function automatic logic [63:0] bits(input int b, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = ldata[b+i];
        return r;
    endfunction

    initial begin
        int b, b2, o, t, bad;
        logic [7:0] kb;

        // ---------------- reset state ----------------
        #12;
        chk("rst_we",    {29'b0, we}, 0);
        chk("rst_flags", {fr, ov, te}, 0);
        chk("rst_addr",  {wa0, wa1, wa2}, 0);
        chk("rst_data",  {61'b0, wd}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- full default frame ----------------
        sel = 0;
        b = lcnt;
        for (int k = 0; k < 98; k++) begin
            send_byte(8'(k));
            repeat (8) @(negedge clk);
        end
        #1;
        chk("full_cnt", lcnt - b, 784);
        bad = 0;
        for (int i = 0; i < 784; i++) begin
            kb = 8'(i / 8);
            if (laddr[b+i] !== 10'(i) || ldata[b+i] !== kb[i % 8]) bad++;
        end
        chk("full_bits", bad, 0);
        chk("full_rdy", s_fr, 1);
        chk("full_rdy_lat", rdy_cyc - last_cyc, 1);
        ack();
        chk("full_ack", s_fr, 0);

        // ---------------- partial last byte ----------------
        sel = 1;
        b = lcnt;
        send_byte(8'hFF); repeat (8) @(negedge clk);
        send_byte(8'h00); repeat (8) @(negedge clk);
        send_byte(8'hA5); repeat (8) @(negedge clk);
        #1;
        chk("part_cnt", lcnt - b, 20);
        chk("part_addr", seq_bad(b, 20, 0), 0);
        chk("part_bits", bits(b, 20), 64'h500FF);
        chk("part_rdy", s_fr, 1);
        chk("part_rdy_lat", rdy_cyc - last_cyc, 1);
        ack();
        chk("part_ack", s_fr, 0);

        // ---------------- overrun ----------------
        b = lcnt;
        o = ovr_cnt;
        send_byte(8'h5A);
        @(negedge clk);
        send_byte(8'hFF);              // sampled on the 3rd UNPACK cycle
        chk("ovr_pulse", s_ov, 1);
        @(negedge clk);
        chk("ovr_once", s_ov, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("ovr_cnt", ovr_cnt - o, 1);
        chk("ovr_wr", lcnt - b, 8);
        chk("ovr_addr", seq_bad(b, 8, 0), 0);
        chk("ovr_bits", bits(b, 8), 64'h5A);
        send_byte(8'h00); repeat (8) @(negedge clk);
        send_byte(8'h0F); repeat (8) @(negedge clk);
        send_byte(8'h77);              // arrives while FULL
        chk("ovr_full", s_ov, 1);
        chk("ovr_full_rdy", s_fr, 1);
        #1;
        chk("ovr_total", lcnt - b, 20);
        chk("ovr_frame_bits", bits(b, 20), 64'hF005A);
        ack();

        // ---------------- timeout ----------------
        sel = 2;
        t = to_cnt;
        for (int k = 0; k < 5; k++) begin
            send_byte(8'(k + 1));
            repeat (8) @(negedge clk);
        end
        repeat (99) @(negedge clk);
        chk("to_early", s_te, 0);
        @(negedge clk);
        chk("to_pulse", s_te, 1);
        @(negedge clk);
        chk("to_once", s_te, 0);
        b2 = lcnt;
        send_byte(8'hC3);
        repeat (8) @(negedge clk);
        #1;
        chk("to_restart_addr", seq_bad(b2, 8, 0), 0);
        chk("to_restart_bits", bits(b2, 8), 64'hC3);
        chk("to_cnt", to_cnt - t, 1);
        repeat (100) @(negedge clk);   // let this partial frame expire too
        #1;

        // ---------------- expiry race ----------------
        b = lcnt;
        t = to_cnt;
        for (int k = 0; k < 5; k++) begin
            send_byte(8'(k + 16));
            repeat (8) @(negedge clk);
        end
        repeat (98) @(negedge clk);
        send_byte(8'h3C);              // sampled exactly on the expiry edge
        repeat (8) @(negedge clk);
        #1;
        chk("race_cnt", lcnt - b, 48);
        chk("race_addr", seq_bad(b + 40, 8, 40), 0);
        chk("race_bits", bits(b + 40, 8), 64'h3C);
        chk("race_no_to", to_cnt - t, 0);

        // ---------------- async reset mid-UNPACK ----------------
        sel = 1;
        t = to_cnt;
        send_byte(8'h3C);
        @(negedge clk);
        chk("pre_rst_we", s_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", s_we, 0);
        chk("rst_async_addr", s_wa, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ack();                         // ignored: loader is IDLE
        chk("ack_idle_rdy", s_fr, 0);
        chk("ack_idle_we", s_we, 0);
        b = lcnt;
        send_byte(8'h81);
        repeat (8) @(negedge clk);
        #1;
        chk("rst_restart_cnt", lcnt - b, 8);
        chk("rst_restart_addr", seq_bad(b, 8, 0), 0);
        chk("rst_restart_bits", bits(b, 8), 64'h81);
        chk("rst_no_to", to_cnt - t, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
